// File: rtl/ftq_sram_pkg.sv
// Shared types and helpers for the FTQ side-band storage array:
// address-width derivation, init FSM state encoding and packed-bus slice offsets.
package ftq_sram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } ftq_sram_state_e;

  // A single-entry-pair array still needs one address bit.
  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int addr_lsb(input int port, input int aw);
    return port * aw;
  endfunction

  function automatic int data_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/ftq_sram_1r1w.sv
// One storage copy: single write port, one registered read port with
// write-first bypass, hold-when-idle and out-of-range reads returning zero.
module ftq_sram_1r1w #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 256,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_wen,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_ren,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_bypass;

  assign w_wr_ok  = i_wen && ({1'b0, i_waddr} < DEPTH_W);
  assign w_rd_ok  = {1'b0, i_raddr} < DEPTH_W;
  assign w_bypass = w_wr_ok && (i_waddr == i_raddr);

  // Storage is deliberately not reset; the top-level init sequencer zeroes it.
  always_ff @(posedge clock) begin
    if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_ren) begin
      if (!w_rd_ok) begin
        r_rdata <= '0;
      end else if (w_bypass) begin
        r_rdata <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_raddr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ftq_nr_sram_multi.sv
// N-read/1-write FTQ side-band array: one replicated copy per read port, shared
// write port, and a reset-time sequencer that zeroes every entry before ready.
module ftq_nr_sram_multi
  import ftq_sram_pkg::*;
#(
  parameter  int NUM_READ = 2,
  parameter  int DEPTH    = 8,
  parameter  int WIDTH    = 256,
  localparam int AW       = calc_aw(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_READ*AW-1:0]    io_raddr,
  input  logic [NUM_READ-1:0]       io_ren,
  output logic [NUM_READ*WIDTH-1:0] io_rdata,
  input  logic [AW-1:0]             io_waddr,
  input  logic                      io_wen,
  input  logic [WIDTH-1:0]          io_wdata,
  output logic                      io_ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  ftq_sram_state_e r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_ready;

  logic                w_init;
  logic                w_wen;
  logic [AW-1:0]       w_waddr;
  logic [WIDTH-1:0]    w_wdata;
  logic [NUM_READ-1:0] w_ren;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == LAST_IDX) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        ST_IDLE: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // While initialising, the write port is stolen for zeroing and reads are gated
  // so the output registers keep the zero they were reset to.
  assign w_init  = (r_state == ST_INIT);
  assign w_wen   = w_init ? 1'b1  : io_wen;
  assign w_waddr = w_init ? r_cnt : io_waddr;
  assign w_wdata = w_init ? '0    : io_wdata;
  assign w_ren   = w_init ? '0    : io_ren;

  for (genvar g = 0; g < NUM_READ; g++) begin : g_copy
    ftq_sram_1r1w #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_copy (
      .clock   (clock),
      .reset   (reset),
      .i_wen   (w_wen),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_ren   (w_ren[g]),
      .i_raddr (io_raddr[addr_lsb(g, AW) +: AW]),
      .o_rdata (io_rdata[data_lsb(g, WIDTH) +: WIDTH])
    );
  end

  assign io_ready = r_ready;

endmodule

// File: tb/tb_ftq_nr_sram_multi.sv
// Scoreboard bench: a DEPTH=8 and a DEPTH=6 instance share stimulus; a reference
// model pushes expected outputs each cycle and they are popped after the edge.
module tb_ftq_nr_sram_multi;

  localparam int NR = 2;
  localparam int W  = 256;
  localparam int AW = 3;

  typedef struct {
    int         d;
    int         kind;
    int         p;
    logic [W-1:0] v;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  raddr;
  logic [NR-1:0]     ren;
  logic [AW-1:0]     waddr;
  logic              wen;
  logic [W-1:0]      wdata;
  logic [NR*W-1:0]   rdata8, rdata6;
  logic              ready8, ready6;

  always #5 clock = ~clock;

  ftq_nr_sram_multi #(.NUM_READ(NR), .DEPTH(8), .WIDTH(W)) u_dut8 (
    .clock(clock), .reset(reset), .io_raddr(raddr), .io_ren(ren), .io_rdata(rdata8),
    .io_waddr(waddr), .io_wen(wen), .io_wdata(wdata), .io_ready(ready8)
  );

  ftq_nr_sram_multi #(.NUM_READ(NR), .DEPTH(6), .WIDTH(W)) u_dut6 (
    .clock(clock), .reset(reset), .io_raddr(raddr), .io_ren(ren), .io_rdata(rdata6),
    .io_waddr(waddr), .io_wen(wen), .io_wdata(wdata), .io_ready(ready6)
  );

  logic [W-1:0] m_mem [2][8];
  logic [W-1:0] m_rd  [2][NR];
  logic         m_ready [2];
  int           m_cnt [2];
  int           dep [2] = '{8, 6};
  exp_t         q [$];
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_ready[d] = 1'b0;
        m_cnt[d]   = 0;
        for (int p = 0; p < NR; p++) m_rd[d][p] = '0;
      end else if (!m_ready[d]) begin
        m_mem[d][m_cnt[d]] = '0;
        if (m_cnt[d] == dep[d] - 1) begin
          m_ready[d] = 1'b1;
          m_cnt[d]   = 0;
        end else begin
          m_cnt[d]++;
        end
      end else begin
        for (int p = 0; p < NR; p++) begin
          int a;
          a = int'(raddr[p*AW +: AW]);
          if (ren[p]) begin
            if (a >= dep[d])                      m_rd[d][p] = '0;
            else if (wen && int'(waddr) == a)     m_rd[d][p] = wdata;
            else                                  m_rd[d][p] = m_mem[d][a];
          end
        end
        if (wen && int'(waddr) < dep[d]) m_mem[d][waddr] = wdata;
      end
      for (int p = 0; p < NR; p++) q.push_back('{d, 0, p, m_rd[d][p]});
      q.push_back('{d, 1, 0, {{(W-1){1'b0}}, m_ready[d]}});
    end
  endtask

  task automatic cyc(input logic r, input logic we, input int wa, input logic [W-1:0] wd,
                     input logic [1:0] re, input int a0, input int a1);
    exp_t         e;
    logic [W-1:0] obs;
    reset = r;
    wen   = we;
    waddr = wa[AW-1:0];
    wdata = wd;
    ren   = re;
    raddr = {a1[AW-1:0], a0[AW-1:0]};
    model_step();
    @(posedge clock);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.kind == 0) obs = (e.d == 0) ? rdata8[e.p*W +: W] : rdata6[e.p*W +: W];
      else             obs = {{(W-1){1'b0}}, (e.d == 0) ? ready8 : ready6};
      check_val($sformatf("d%0d_%s%0d", dep[e.d], (e.kind == 0) ? "rdata_p" : "ready", e.p), obs, e.v);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, '0, 2'b00, 0, 0);
  endtask

  task automatic wr(input int a, input logic [W-1:0] v);
    cyc(1'b0, 1'b1, a, v, 2'b00, 0, 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) cyc(1'b0, 1'b0, 0, '0, 2'b11, a, 7 - a);
  endtask

  initial begin
    // Reset, then noisy init: wen/ren during INIT must be ignored.
    cyc(1'b1, 1'b0, 0, '0, 2'b00, 0, 0);
    cyc(1'b1, 1'b0, 0, '0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, i, rnd_w(), 2'b11, i, i);
    cyc(1'b1, 1'b0, 0, '0, 2'b00, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, i % 8, rnd_w(), 2'b11, i % 8, 7 - (i % 8));
    read_all();

    // Basic write then read; port1 idle.
    wr(3, 256'hA5);
    cyc(1'b0, 1'b0, 0, '0, 2'b01, 3, 0);
    idle(1);

    // Bypass on port0, old data on port1, then hold.
    wr(5, 256'h11);
    wr(4, 256'h44);
    cyc(1'b0, 1'b1, 5, 256'h22, 2'b11, 5, 4);
    idle(10);
    // Both ports hitting the same in-flight write.
    cyc(1'b0, 1'b1, 2, 256'h5A5A, 2'b11, 2, 2);
    idle(1);

    // Independent ports at the array boundaries.
    wr(0, 256'hDEAD);
    wr(7, 256'hBEEF);
    cyc(1'b0, 1'b0, 0, '0, 2'b11, 0, 7);
    idle(1);

    // Out of range on the DEPTH=6 copy; DEPTH=8 copy accepts it.
    wr(7, 256'hFF);
    cyc(1'b0, 1'b0, 0, '0, 2'b11, 7, 6);
    read_all();

    // Reset mid-operation with non-zero read data on port0.
    wr(2, 256'h33);
    cyc(1'b0, 1'b0, 0, '0, 2'b01, 2, 0);
    cyc(1'b1, 1'b0, 0, '0, 2'b00, 0, 0);
    idle(10);
    read_all();

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), rnd_w(),
          2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7));
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
